// File: rtl/example_module_ctr.sv
// example_module_ctr
// Free-running up-counter with a programmable step, terminal value and clock
// prescaler. The count advances once every PRESCALE clock cycles; an advance
// that would carry the count past MAX_COUNT wraps it to 0 instead. All state
// is cleared by a synchronous, active-high reset.

module example_module_ctr #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    // The prescaler needs at least one bit even when PRESCALE is 1, in which
    // case it sits at 0 and every cycle is an advance.
    localparam int unsigned      PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    // Step and terminal value carried one bit wider than the count so the
    // carry-out of count+STEP takes part in the terminal comparison.
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0] MAX_EXT  = (WIDTH + 1)'(MAX_COUNT);

    logic [PRE_W-1:0] r_pre;
    logic [WIDTH-1:0] r_count;

    logic             w_advance;
    logic [PRE_W-1:0] w_next_pre;
    logic [WIDTH:0]   w_sum;
    logic             w_fits;
    logic [WIDTH-1:0] w_next_count;

    // An advance happens on the last cycle of each prescale period.
    assign w_advance  = (r_pre == PRE_LAST);
    assign w_next_pre = w_advance ? '0 : r_pre + PRE_W'(1);

    // A count above MAX_COUNT (unreachable) also fails this test, so it
    // falls back to 0 on the next advance like any other overflow.
    assign w_sum        = {1'b0, r_count} + STEP_EXT;
    assign w_fits       = (w_sum <= MAX_EXT);
    assign w_next_count = w_fits ? w_sum[WIDTH-1:0] : '0;

    // Prescaler and count registers; reset wins over an advance on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled only here, on the clock edge; it is not in the
        // sensitivity list, and non-blocking assignments keep every register
        // reading the pre-edge values of the others.
        if (reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_pre <= w_next_pre;
            if (w_advance) begin
                r_count <= w_next_count;
            end
        end
    end

    // The output is the register itself: no logic between inputs and count.
    assign count = r_count;

endmodule

// File: tb/tb_example_module_ctr.sv
// tb_example_module_ctr
// Six counters with different parameter sets share one clock and one reset.
// The driver applies directed phases followed by random resets and, for every
// edge, pushes the expected count of each instance into a scoreboard queue.
// The expected value comes from a closed form: after n non-reset edges there
// have been n/PRESCALE advances, and the visited values are k*STEP for
// k = 0 .. MAX_COUNT/STEP, repeating. A monitor pops and compares after
// every edge.

module tb_example_module_ctr;

    localparam int NDUT = 6;

    typedef logic [NDUT-1:0][7:0] exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] c0, c1, c2, c3, c5;
    logic [3:0] c4;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   n           = 0;  // non-reset edges since the last reset edge

    // 0: defaults
    example_module_ctr u_d0 (.clk(clk), .reset(reset), .count(c0));
    // 1: prescaler of 4
    example_module_ctr #(.PRESCALE(4)) u_d1 (.clk(clk), .reset(reset), .count(c1));
    // 2: step 3, terminal 10
    example_module_ctr #(.STEP(3), .MAX_COUNT(10)) u_d2 (.clk(clk), .reset(reset), .count(c2));
    // 3: terminal 0, must stay at 0
    example_module_ctr #(.MAX_COUNT(0)) u_d3 (.clk(clk), .reset(reset), .count(c3));
    // 4: narrow counter whose sum carries out of WIDTH bits (14+7 = 21)
    example_module_ctr #(.WIDTH(4), .STEP(7), .MAX_COUNT(15), .PRESCALE(2))
        u_d4 (.clk(clk), .reset(reset), .count(c4));
    // 5: mixed parameters
    example_module_ctr #(.STEP(5), .MAX_COUNT(200), .PRESCALE(3))
        u_d5 (.clk(clk), .reset(reset), .count(c5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected count after n non-reset edges, from the parameter set alone.
    function automatic int model(input int edges, input int pre, input int step, input int max);
        int advances = edges / pre;
        int period   = max / step + 1;
        return (advances % period) * step;
    endfunction

    function automatic exp_t expected(input int edges);
        exp_t e;
        e[0] = 8'(model(edges, 1, 1, 255));
        e[1] = 8'(model(edges, 4, 1, 255));
        e[2] = 8'(model(edges, 1, 3, 10));
        e[3] = 8'(model(edges, 1, 1, 0));
        e[4] = 8'(model(edges, 2, 7, 15));
        e[5] = 8'(model(edges, 3, 5, 200));
        return e;
    endfunction

    // One clock edge: set reset between edges, update the model, push the
    // expected counts for the coming edge.
    task automatic step(input logic rst);
        @(negedge clk);
        reset = rst;
        if (rst) n = 0;
        else     n = n + 1;
        exp_q.push_back(expected(n));
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s d%0d at t=%0t: count=%0d expected=%0d", name, idx, $time, act, exp);
        end
    endtask

    // Monitor: one output set per edge, compared just after the edge.
    initial begin
        exp_t       e;
        exp_t       act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                act[0] = c0;
                act[1] = c1;
                act[2] = c2;
                act[3] = c3;
                act[4] = {4'b0000, c4};
                act[5] = c5;
                for (int i = 0; i < NDUT; i++) begin
                    check("count", i, act[i], e[i]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;

        // Reset held for two edges, then a long run through the 255 -> 0 wrap.
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);

        // Mid-count reset when the default counter reads 0x37.
        while ((n % 256) != 8'h37) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b0);

        // Reset on the edge where the PRESCALE=4 counter would advance; the
        // following run shows its prescaler restarted from 0.
        while (((n + 1) % 4) != 0) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 12; i++) step(1'b0);

        // Random stretch with occasional resets of random length.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b0);

        // Drain the scoreboard.
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/example_module_ctr.md
EXAMPLE_MODULE_CTR -- requirements
Module: example_module_ctr

Interface
- REQ-001 The block SHALL be parameterised as follows (name, default, meaning):
  - WIDTH, 8, bit width of count.
  - STEP, 1, increment added per advance; legal range 1..2^WIDTH-1.
  - MAX_COUNT, 2^WIDTH-1, terminal value; legal range 0..2^WIDTH-1.
  - PRESCALE, 1, clock cycles per advance; legal range 1..65535.
- REQ-002 The block SHALL have the following ports (name direction width meaning):
  - clk input 1, single clock, all state updates on rising edge.
  - reset input 1, synchronous, active-high; sampled only on the rising edge of clk.
  - count output WIDTH, current counter value, driven directly from a register.
- REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
- REQ-004 count SHALL have no combinational path from any input.

Function
- REQ-005 The block SHALL contain an internal prescale counter, pre, with range 0..PRESCALE-1.
- REQ-006 An "advance" SHALL occur on a rising edge of clk when reset is low and pre equals PRESCALE-1.
  - When PRESCALE=1, every non-reset edge SHALL be an advance.
- REQ-007 On each non-reset edge:
  - pre SHALL increment by 1.
  - pre SHALL wrap to 0 after reaching PRESCALE-1.
- REQ-008 On an advance, count SHALL change as follows:
  - If count+STEP <= MAX_COUNT, count SHALL become count+STEP.
  - Otherwise count SHALL wrap to 0.
- REQ-009 The comparison count+STEP <= MAX_COUNT SHALL be evaluated at WIDTH+1 bits so carry-out is never lost.
- REQ-010 On non-advance, non-reset edges, count SHALL hold its value.
- REQ-011 If count is ever greater than MAX_COUNT, the next advance SHALL load 0. This state is unreachable by design; the rule defines behaviour for it.
- REQ-012 With default parameters, count SHALL:
  - increment by exactly 1 on every clock edge;
  - go 255 -> 0 with no stall cycle;
  - give a full period of 256 cycles.
- REQ-013 Latency SHALL be as follows:
  - The first advance after reset deasserts SHALL occur on the PRESCALE-th rising edge with reset low.
  - count SHALL reflect the new value immediately after that edge.
- REQ-014 If MAX_COUNT=0, count SHALL remain 0 permanently.

Reset
- REQ-015 While reset is high at a rising edge, count SHALL be loaded with 0 and pre SHALL be loaded with 0.
- REQ-016 Reset SHALL take priority over advance on the same edge.
- REQ-017 Reset asserted mid-count SHALL force count to 0 at the next rising edge regardless of the pre value.
- REQ-018 Deasserting reset SHALL restart counting from 0 per REQ-013.
- REQ-019 Asserting reset between clock edges SHALL have no effect until the next rising edge.
- REQ-020 Before the first reset, count is undefined. Simulation SHALL NOT rely on an initial value.

Verification
- REQ-021 Default parameters:
  - Stimulus: reset high for 2 edges, then low.
  - Required: count=0 during reset; count=1,2,3... on successive edges; count=10 after 10 edges.
- REQ-022 Wrap, default parameters:
  - Stimulus: run 256 edges after reset.
  - Required: count goes 254, 255, 0, 1 with no hold.
- REQ-023 Mid-count reset:
  - Stimulus: at count=0x37, assert reset for 1 edge.
  - Required: count=0 after that edge; count=1 one edge after release.
- REQ-024 PRESCALE=4, STEP=1:
  - Stimulus: release reset.
  - Required: count stays 0 for edges 1-3, becomes 1 on edge 4 and 2 on edge 8.
- REQ-025 STEP=3, MAX_COUNT=10:
  - Stimulus: release reset.
  - Required: sequence 0, 3, 6, 9, 0, 3 (9+3>10 wraps to 0).
- REQ-026 Reset priority:
  - Stimulus: assert reset on the same edge an advance would occur (PRESCALE=4, edge 4).
  - Required: count=0 and pre=0 after that edge.
